// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind the 32-input MAC cluster: sums LEN 17-bit terms
// and hands the result over a valid/ready port, stalling the cluster until it is taken.
module mac_accumulator #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ACC_WIDTH  = 32,
  parameter  int LEN        = 16,
  localparam int CNT_WIDTH  = $clog2(LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ebl,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_sum,
  input  logic                  in_carry,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic                  out_overflow,
  output logic [CNT_WIDTH-1:0]  term_cnt
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                 state, state_next;
  logic [ACC_WIDTH-1:0]   acc, acc_next, out_acc_next;
  logic                   ovf, ovf_next, out_ovf_next, out_valid_next;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic [ACC_WIDTH:0]     term_ext, sum_ext;
  logic                   accept, last, add_carry;

  // The carry-out of the cluster adder is the MSB of the term, never a sign bit.
  assign term_ext  = (ACC_WIDTH + 1)'({in_carry, in_sum});
  assign sum_ext   = {1'b0, acc} + term_ext;
  assign add_carry = sum_ext[ACC_WIDTH];

  assign in_ready = ~rst & ebl & ~clear & (state == ACCUM);
  assign accept   = in_valid & in_ready;
  assign last     = (term_cnt == CNT_WIDTH'(LEN - 1));

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    ovf_next       = ovf;
    cnt_next       = term_cnt;
    out_valid_next = out_valid;
    out_acc_next   = out_acc;
    out_ovf_next   = out_overflow;
    if (ebl) begin
      if (clear) begin
        state_next     = ACCUM;
        acc_next       = '0;
        ovf_next       = 1'b0;
        cnt_next       = '0;
        out_valid_next = 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              if (last) begin
                out_acc_next   = sum_ext[ACC_WIDTH-1:0];
                out_ovf_next   = ovf | add_carry;
                out_valid_next = 1'b1;
                state_next     = DONE;
                acc_next       = '0;
                ovf_next       = 1'b0;
                cnt_next       = '0;
              end else begin
                acc_next = sum_ext[ACC_WIDTH-1:0];
                ovf_next = ovf | add_carry;
                cnt_next = term_cnt + 1'b1;
              end
            end
          end
          DONE: begin
            // Input reopens only on the cycle after the handshake.
            if (out_valid && out_ready) begin
              out_valid_next = 1'b0;
              state_next     = ACCUM;
            end
          end
          default: state_next = ACCUM;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      ovf          <= 1'b0;
      term_cnt     <= '0;
      out_valid    <= 1'b0;
      out_acc      <= '0;
      out_overflow <= 1'b0;
    end else begin
      state        <= state_next;
      acc          <= acc_next;
      ovf          <= ovf_next;
      term_cnt     <= cnt_next;
      out_valid    <= out_valid_next;
      out_acc      <= out_acc_next;
      out_overflow <= out_ovf_next;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: unit "a" (LEN=4, 32-bit) covers handshake,
// stall, clear and reset; unit "b" (LEN=16, 20-bit) covers wrap and sticky overflow.
module tb_mac_accumulator;

  typedef struct packed {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ebl, clear, in_valid, in_carry, out_ready;
  logic [15:0] in_sum;
  logic        in_ready, out_valid, out_overflow;
  logic [31:0] out_acc;
  logic [2:0]  term_cnt;

  logic        b_ebl, b_clear, b_in_valid, b_in_carry, b_out_ready;
  logic [15:0] b_in_sum;
  logic        b_in_ready, b_out_valid, b_out_overflow;
  logic [19:0] b_out_acc;
  logic [4:0]  b_term_cnt;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  mac_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .LEN(4)) dut_a (
    .clk(clk), .rst(rst), .ebl(ebl), .clear(clear),
    .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_overflow(out_overflow), .term_cnt(term_cnt)
  );

  mac_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(20), .LEN(16)) dut_b (
    .clk(clk), .rst(rst), .ebl(b_ebl), .clear(b_clear),
    .in_valid(b_in_valid), .in_sum(b_in_sum), .in_carry(b_in_carry), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_acc(b_out_acc),
    .out_overflow(b_out_overflow), .term_cnt(b_term_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitors pop the scoreboard on every completed output handshake.
  always @(negedge clk) begin
    if (!rst && ebl && out_valid && out_ready) begin
      if (exp_a.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL a_unexpected_result: got 0x%0h, expected none", out_acc);
      end else begin
        exp_t e;
        e = exp_a.pop_front();
        check_output("a_result_acc", out_acc, e.acc);
        check_output("a_result_ovf", {31'b0, out_overflow}, {31'b0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_ebl && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL b_unexpected_result: got 0x%0h, expected none", b_out_acc);
      end else begin
        exp_t e;
        e = exp_b.pop_front();
        check_output("b_result_acc", {12'b0, b_out_acc}, e.acc);
        check_output("b_result_ovf", {31'b0, b_out_overflow}, {31'b0, e.ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one term on unit a and returns 1 time unit after the edge that accepted it.
  task automatic apply_stimulus(input logic c, input logic [15:0] s);
    int guard;
    in_valid = 1'b1;
    in_carry = c;
    in_sum   = s;
    guard    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        break;
      end
      guard++;
      if (guard > 50) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL a_accept_timeout: in_ready=%0b, required 1", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_b(input logic c, input logic [15:0] s);
    int guard;
    b_in_valid = 1'b1;
    b_in_carry = c;
    b_in_sum   = s;
    guard      = 0;
    forever begin
      @(negedge clk);
      if (b_in_ready) begin
        tick();
        break;
      end
      guard++;
      if (guard > 50) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL b_accept_timeout: in_ready=%0b, required 1", b_in_ready);
        break;
      end
    end
    b_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; ebl = 1'b1; clear = 1'b0; in_valid = 1'b0; in_carry = 1'b0;
    in_sum = '0; out_ready = 1'b1;
    b_ebl = 1'b1; b_clear = 1'b0; b_in_valid = 1'b0; b_in_carry = 1'b0;
    b_in_sum = '0; b_out_ready = 1'b1;
    tick();
    tick();
    check_output("reset_in_ready", {31'b0, in_ready}, 32'd0);
    check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("reset_out_acc", out_acc, 32'd0);
    check_output("reset_term_cnt", {29'b0, term_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    check_output("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic sum 1+2+3+4 with one cycle of back-pressure while the result drains.
    exp_a.push_back('{acc: 32'd10, ovf: 1'b0});
    apply_stimulus(1'b0, 16'd1);
    apply_stimulus(1'b0, 16'd2);
    apply_stimulus(1'b0, 16'd3);
    apply_stimulus(1'b0, 16'd4);
    check_output("basic_out_valid", {31'b0, out_valid}, 32'd1);
    check_output("basic_term_cnt", {29'b0, term_cnt}, 32'd0);
    check_output("basic_in_ready_low", {31'b0, in_ready}, 32'd0);
    tick();
    check_output("basic_in_ready_back", {31'b0, in_ready}, 32'd1);
    check_output("basic_out_valid_drop", {31'b0, out_valid}, 32'd0);

    // Carry bit is part of the term.
    exp_a.push_back('{acc: 32'h7FFFC, ovf: 1'b0});
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 16'hFFFF);
    tick();

    // Back-pressure: result held for 5 cycles.
    exp_a.push_back('{acc: 32'd100, ovf: 1'b0});
    out_ready = 1'b0;
    apply_stimulus(1'b0, 16'd10);
    apply_stimulus(1'b0, 16'd20);
    apply_stimulus(1'b0, 16'd30);
    apply_stimulus(1'b0, 16'd40);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check_output("bp_out_acc", out_acc, 32'd100);
      check_output("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_output("bp_out_valid_drop", {31'b0, out_valid}, 32'd0);
    check_output("bp_in_ready_back", {31'b0, in_ready}, 32'd1);

    // ebl stall freezes the count; offered term must not be consumed.
    exp_a.push_back('{acc: 32'd16, ovf: 1'b0});
    apply_stimulus(1'b0, 16'd5);
    apply_stimulus(1'b0, 16'd7);
    check_output("stall_cnt_before", {29'b0, term_cnt}, 32'd2);
    ebl = 1'b0; in_valid = 1'b1; in_sum = 16'd99;
    tick(); tick(); tick();
    check_output("stall_cnt_frozen", {29'b0, term_cnt}, 32'd2);
    check_output("stall_in_ready", {31'b0, in_ready}, 32'd0);
    ebl = 1'b1; in_valid = 1'b0;
    apply_stimulus(1'b0, 16'd3);
    apply_stimulus(1'b0, 16'd1);
    tick();

    // Clear drops the partial 9 and the term offered alongside it.
    exp_a.push_back('{acc: 32'd4, ovf: 1'b0});
    apply_stimulus(1'b0, 16'd9);
    check_output("clear_cnt_before", {29'b0, term_cnt}, 32'd1);
    clear = 1'b1; in_valid = 1'b1; in_sum = 16'd100;
    #1;
    check_output("clear_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check_output("clear_term_cnt", {29'b0, term_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 16'd1);
    tick();

    // Reset after 3 of 4 terms.
    apply_stimulus(1'b0, 16'd2);
    apply_stimulus(1'b0, 16'd2);
    apply_stimulus(1'b0, 16'd2);
    check_output("rst_mid_cnt_before", {29'b0, term_cnt}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_output("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("rst_mid_out_acc", out_acc, 32'd0);
    check_output("rst_mid_term_cnt", {29'b0, term_cnt}, 32'd0);
    check_output("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    exp_a.push_back('{acc: 32'd8, ovf: 1'b0});
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 16'd2);
    tick();

    // Reset while a result is pending: it is discarded.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 16'd3);
    check_output("rst_done_out_valid_before", {31'b0, out_valid}, 32'd1);
    check_output("rst_done_out_acc_before", out_acc, 32'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_output("rst_done_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("rst_done_out_acc", out_acc, 32'd0);
    check_output("rst_done_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    exp_a.push_back('{acc: 32'd8, ovf: 1'b0});
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 16'd2);
    tick();

    // Unit b: 16 x 0x1FFFF wraps 20 bits, then sticky flag clears for next vector.
    exp_b.push_back('{acc: 32'hFFFF0, ovf: 1'b1});
    for (int i = 0; i < 16; i++) apply_b(1'b1, 16'hFFFF);
    exp_b.push_back('{acc: 32'd16, ovf: 1'b0});
    for (int i = 0; i < 16; i++) apply_b(1'b0, 16'd1);
    tick(); tick(); tick();

    check_output("a_scoreboard_drained", exp_a.size(), 32'd0);
    check_output("b_scoreboard_drained", exp_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream stage of the 32-input MAC cluster.
- Consumes the cluster's per-cycle 16-bit pair sum plus carry-out, treated as a 17-bit unsigned term.
- Accumulates LEN terms into one dot-product result and presents it on a valid/ready output port.
- Applies back-pressure to the cluster pipeline through in_ready while a finished result is unconsumed.

Parameters:
- DATA_WIDTH, 16, width of in_sum; matches the cluster product/sum width.
- ACC_WIDTH, 32, accumulator and result width; must be >= DATA_WIDTH+1.
- LEN, 16, terms per output vector; must be >= 1.
- CNT_WIDTH (localparam), $clog2(LEN+1), width of term_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ebl  in  1  global enable; when low, all state freezes.
- clear  in  1  synchronous flush of partial accumulation and any pending result.
- in_valid  in  1  term present on in_sum/in_carry.
- in_sum  in  DATA_WIDTH  cluster pair sum.
- in_carry  in  1  cluster adder carry-out; forms the MSB of the term.
- in_ready  out  1  block can accept a term this cycle.
- out_valid  out  1  out_acc/out_overflow hold a completed vector result.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_WIDTH  accumulated result.
- out_overflow  out  1  sticky overflow for the vector in out_acc.
- term_cnt  out  CNT_WIDTH  terms accepted in the current vector.

Behaviour:
- Reset (rst=1 at a clk edge), highest priority, independent of ebl:
  - state=ACCUM, internal acc=0, term_cnt=0, ovf=0.
  - out_valid=0, out_acc=0, out_overflow=0.
  - in_ready=0 during the reset cycle and follows the normal rule after.
- Term formation: term = {in_carry, in_sum}, zero-extended to ACC_WIDTH+1 for the add.
- Accept: accept = ebl & in_valid & in_ready.
  - in_ready is combinational: ebl & ~clear & (state==ACCUM).
- State ACCUM, on accept with term_cnt < LEN-1:
  - acc <= acc + term (low ACC_WIDTH bits).
  - ovf <= ovf | carry out of bit ACC_WIDTH-1.
  - term_cnt <= term_cnt+1.
- State ACCUM, on accept with term_cnt == LEN-1 (last term):
  - out_acc <= acc+term.
  - out_overflow <= ovf | carry.
  - out_valid <= 1; state <= DONE.
  - acc <= 0; ovf <= 0; term_cnt <= 0.
  - Latency: the result is visible the cycle after the last term is accepted.
- LEN=1: every accepted term produces a result directly.
- State DONE:
  - in_ready=0.
  - out_acc/out_overflow held stable while out_valid=1.
  - When ebl & out_valid & out_ready at the edge: out_valid <= 0, state <= ACCUM. in_ready rises the following cycle; there is no same-cycle pass-through.
- ebl=0: no accept, no output handshake, state/acc/term_cnt/out_* frozen. out_valid stays asserted if set.
- clear=1 with ebl=1, priority below rst:
  - acc=0, ovf=0, term_cnt=0, state=ACCUM, out_valid=0.
  - The input term in that cycle is discarded (in_ready=0).
  - out_acc keeps its last value (don't-care while out_valid=0).
  - clear with ebl=0 is ignored.
- Wrap: acc wraps modulo 2^ACC_WIDTH; out_overflow=1 iff any partial add in that vector carried out.
- in_valid while in_ready=0: the term is not consumed; the upstream must hold it.
- Reset mid-vector: partial sum lost; the next vector starts at term 0.

Test Plan:
- Basic sum, LEN=4, ACC_WIDTH=32: terms sum=1,2,3,4, carry=0, back-to-back, out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_acc=10, out_overflow=0, term_cnt=0. in_ready low for exactly 1 cycle.
- Carry inclusion, LEN=4: 4 terms {carry=1, sum=0xFFFF} -> out_acc=0x7FFFC, out_overflow=0.
- Overflow/wrap, LEN=16, ACC_WIDTH=20: 16 terms of 0x1FFFF -> out_acc=0xFFFF0, out_overflow=1. The next vector of 16 terms of value 1 -> out_acc=16, out_overflow=0 (sticky cleared).
- Back-pressure, LEN=4: out_ready=0 for 5 cycles after the result -> out_valid and out_acc held, in_ready=0 for all 5 cycles. out_ready=1 -> out_valid drops next edge, in_ready=1 the cycle after.
- ebl stall and clear, LEN=4:
  - Accept 2 terms (5,7); ebl=0 for 3 cycles with in_valid=1 -> term_cnt stays 2.
  - Resume with 3,1 -> out_acc=16.
  - In a new vector, accept 9; assert clear one cycle with in_valid=1, in_sum=100 -> term_cnt=0. Then 1,1,1,1 -> out_acc=4.
- Reset mid-operation: after 3 of 4 terms, or while in DONE with out_ready=0 -> next cycle out_valid=0, out_acc=0, term_cnt=0, in_ready=1. A subsequent 4-term vector 2,2,2,2 -> out_acc=8.
